// File: rtl/analog_status_pkg.sv
// Shared offsets and ADC tracker state for the analog status sampler.
package analog_status_pkg;
  localparam int MAX_FLAGS      = 16;
  localparam int STATUS_RAW_LSB = 16;
  localparam int STATUS_DEB_LSB = 0;
  localparam int FALL_LSB       = 16;
  localparam int RISE_LSB       = 0;
  localparam int COUNT_LSB      = 16;
  localparam int MAX_LSB        = 16;

  typedef struct packed {
    logic [15:0] last;
    logic [15:0] count;
    logic [15:0] min;
    logic [15:0] max;
    logic        valid;
  } adc_state_t;
endpackage

// File: rtl/analog_status_sampler_if.sv
// Flag/ADC inputs and status word outputs of the analog status sampler.
interface analog_status_sampler_if #(
  parameter int NUM_FLAGS = 8,
  parameter int ADC_W     = 12
);
  logic [NUM_FLAGS-1:0] flags_async;
  logic [31:0]          clr_sticky;
  logic [ADC_W-1:0]     adc_data;
  logic                 adc_valid;
  logic                 clr_minmax;
  logic [31:0]          status_0;
  logic [31:0]          status_1;
  logic [31:0]          status_2;
  logic [31:0]          status_3;

  modport master (
    output flags_async, clr_sticky, adc_data, adc_valid, clr_minmax,
    input  status_0, status_1, status_2, status_3
  );
  modport slave (
    input  flags_async, clr_sticky, adc_data, adc_valid, clr_minmax,
    output status_0, status_1, status_2, status_3
  );
endinterface

// File: rtl/analog_flag_debounce.sv
// One analog flag: synchroniser chain, stability counter, debounced level
// and single-cycle rise/fall strobes coincident with the deb update edge.
module analog_flag_debounce #(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 16
) (
  input  logic clk_in,
  input  logic reset,
  input  logic flag_async,
  output logic sync,
  output logic deb,
  output logic rise,
  output logic fall
);
  localparam logic [7:0] CNT_MAX = 8'(DEB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] chain;
  logic [7:0]             cnt;
  logic                   flip;

  assign sync = chain[SYNC_STAGES-1];
  assign flip = (sync != deb) && (cnt == CNT_MAX);
  assign rise = flip && sync;
  assign fall = flip && !sync;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      chain <= '0;
      cnt   <= '0;
      deb   <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], flag_async};
      if (sync == deb) begin
        cnt <= '0;
      end else if (flip) begin
        deb <= sync;
        cnt <= '0;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end
endmodule

// File: rtl/analog_status_sampler.sv
// Builds the four status words: sync/debounced flags, sticky edge events,
// and ADC last sample / count / running min-max.
module analog_status_sampler
  import analog_status_pkg::*;
#(
  parameter int NUM_FLAGS   = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 16,
  parameter int ADC_W       = 12
) (
  input logic clk_in,
  input logic reset,
  analog_status_sampler_if.slave bus
);
  logic [MAX_FLAGS-1:0] raw_ext, deb_ext, rise_ext, fall_ext;
  logic [31:0]          sticky, sticky_set;
  logic [15:0]          adc_ext;
  adc_state_t           st;

  for (genvar i = 0; i < MAX_FLAGS; i++) begin : g_flag
    if (i < NUM_FLAGS) begin : g_used
      analog_flag_debounce #(
        .SYNC_STAGES(SYNC_STAGES),
        .DEB_CYCLES (DEB_CYCLES)
      ) u_deb (
        .clk_in    (clk_in),
        .reset     (reset),
        .flag_async(bus.flags_async[i]),
        .sync      (raw_ext[i]),
        .deb       (deb_ext[i]),
        .rise      (rise_ext[i]),
        .fall      (fall_ext[i])
      );
    end else begin : g_unused
      assign raw_ext[i]  = 1'b0;
      assign deb_ext[i]  = 1'b0;
      assign rise_ext[i] = 1'b0;
      assign fall_ext[i] = 1'b0;
    end
  end

  always_comb begin
    sticky_set = '0;
    sticky_set[RISE_LSB +: MAX_FLAGS] = rise_ext;
    sticky_set[FALL_LSB +: MAX_FLAGS] = fall_ext;
    adc_ext = '0;
    adc_ext[ADC_W-1:0] = bus.adc_data;
  end

  // Set is OR-ed after the clear so a coincident edge event wins.
  always_ff @(posedge clk_in) begin
    if (reset) sticky <= '0;
    else       sticky <= (sticky & ~bus.clr_sticky) | sticky_set;
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      st <= '0;
    end else if (bus.adc_valid) begin
      st.last  <= adc_ext;
      st.count <= st.count + 16'd1;
      st.valid <= 1'b1;
      if (!st.valid || bus.clr_minmax) begin
        st.min <= adc_ext;
        st.max <= adc_ext;
      end else begin
        if (adc_ext < st.min) st.min <= adc_ext;
        if (adc_ext > st.max) st.max <= adc_ext;
      end
    end else if (bus.clr_minmax) begin
      st.min   <= '0;
      st.max   <= '0;
      st.valid <= 1'b0;
    end
  end

  always_comb begin
    bus.status_0 = '0;
    bus.status_0[STATUS_RAW_LSB +: MAX_FLAGS] = raw_ext;
    bus.status_0[STATUS_DEB_LSB +: MAX_FLAGS] = deb_ext;
    bus.status_1 = sticky;
    bus.status_2 = '0;
    bus.status_2[COUNT_LSB +: 16] = st.count;
    bus.status_2[0 +: 16]         = st.last;
    bus.status_3 = '0;
    bus.status_3[MAX_LSB +: 16]   = st.max;
    bus.status_3[0 +: 16]         = st.min;
  end
endmodule

// File: doc/analog_status_sampler.md
Name: analog_status_sampler

Overview:
- Upstream producer of the four 32-bit status words read over APB by the analog status register block.
- Synchronises and debounces raw digital flags coming out of the analog macro (comparators, PLL lock, LDO good, ...), keeps sticky rise/fall event bits, and tracks ADC results (last sample, sample count, min/max).
- Drives status_0..status_3 directly; all outputs are registered.

Parameters:
- NUM_FLAGS, 8, number of analog flag inputs (1..16).
- SYNC_STAGES, 2, synchroniser flop depth per flag (>=2).
- DEB_CYCLES, 16, consecutive stable cycles needed before a debounced flag changes (2..255).
- ADC_W, 12, ADC sample width (1..16).

Ports:
- clk_in  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- flags_async  in  NUM_FLAGS  raw flags from the analog domain, asynchronous to clk_in.
- clr_sticky  in  32  one-cycle write-1-to-clear mask, bit-aligned with status_1.
- adc_data  in  ADC_W  ADC result, synchronous to clk_in.
- adc_valid  in  1  one-cycle qualifier for adc_data.
- clr_minmax  in  1  one-cycle pulse that restarts min/max tracking.
- status_0  out  32  [31:16] synchronised raw flags, [15:0] debounced flags, zero-extended.
- status_1  out  32  [31:16] sticky fall events, [15:0] sticky rise events.
- status_2  out  32  [31:16] sample count, [15:0] last sample, zero-extended.
- status_3  out  32  [31:16] max sample, [15:0] min sample, zero-extended.

Behaviour:
- One clock domain; reset is synchronous and active-high.
- Reset:
  - All outputs, synchroniser flops, debounce counters, debounced flags, sticky bits, count, min/max and the min/max-valid flag clear to 0 on the next clk_in edge.
  - Reset mid-debounce discards the in-progress count.
  - Bits for flags at index >= NUM_FLAGS are constant 0.
- Synchroniser:
  - sync[i] is flags_async[i] after SYNC_STAGES flops.
  - status_0[16+i] = sync[i].
- Debounce, per flag:
  - When sync != deb, the counter increments; when sync == deb, the counter clears to 0.
  - When the counter equals DEB_CYCLES-1 and sync != deb, deb takes sync on that edge and the counter clears.
  - A change held steady on flags_async appears on status_0[i] SYNC_STAGES+DEB_CYCLES cycles after the first sampling edge.
  - A glitch shorter than DEB_CYCLES cycles at sync never changes deb.
- Sticky events:
  - On the edge where deb goes 0->1, status_1[i] sets; on 1->0, status_1[16+i] sets.
  - clr_sticky bits clear the matching sticky bits on the next edge.
  - If a set and a clear hit the same bit in the same cycle, set wins.
  - Writes to unused bits have no effect.
- ADC:
  - On adc_valid: last sample <= adc_data, and count <= count+1 (16-bit, wraps 0xFFFF->0x0000, no saturation).
  - If the min/max-valid flag is 0: min <= max <= adc_data and the flag sets.
  - Otherwise min <= min(min, adc_data) and max <= max(max, adc_data), unsigned compare.
  - clr_minmax alone: min <= 0, max <= 0, flag <= 0.
  - clr_minmax together with adc_valid: min <= max <= adc_data and the flag stays 1, i.e. tracking restarts with this sample.
  - clr_minmax does not affect count or the last sample.
- Latency:
  - Every ADC-derived field updates exactly one cycle after the adc_valid edge.
  - adc_valid is never back-pressured; a sample is accepted every cycle it is asserted.

Decomposition:
- Package analog_status_pkg holds:
  - the bit offsets STATUS_RAW_LSB=16, STATUS_DEB_LSB=0, FALL_LSB=16, RISE_LSB=0, COUNT_LSB=16, MAX_LSB=16;
  - MAX_FLAGS=16;
  - a struct typedef for the ADC tracker state (last, count, min, max, valid).
- One sub-module is natural: analog_flag_debounce. It covers a single flag (synchroniser, counter, deb, and rise/fall strobes) and is instantiated NUM_FLAGS times in a generate loop.
- ADC tracking and sticky logic stay in the top module.

Test Plan:
1. Reset, then flags_async[0]=1 held (defaults) -> status_0[16]=1 after 2 cycles. status_0[0]=0 through cycle 17 and 1 from cycle 18. status_1=0x0000_0001.
2. flags_async[1] high for 10 cycles then low -> status_0[1]=0 and status_1[1]=0 throughout; status_0[17] pulses for 10 cycles.
3. Flag 0 dropped after test 1 -> status_0[0]=0 after 18 cycles and status_1=0x0001_0001. Then clr_sticky=0x0001_0001 -> status_1=0x0000_0000 next cycle. Then clr_sticky[0] coincident with a new rise strobe -> status_1[0] remains 1.
4. adc_valid samples 0x100, 0x050, 0xFFF -> status_2=0x0003_0FFF, status_3=0x0FFF_0050.
5. 65536 adc_valid pulses -> status_2[31:16]=0x0000. Then clr_minmax together with sample 0x123 -> status_3=0x0123_0123. clr_minmax alone -> status_3=0x0000_0000, and the next sample 0x7 gives 0x0007_0007.
6. flags_async[2] toggled, reset asserted 8 cycles into the debounce window -> all status words 0 next cycle. After reset release the debounce restarts from 0 with full 18-cycle latency.
